// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the branch resolution unit: compare codes, branch types and FSM states.
package branch_resolve_pkg;

    localparam logic [1:0] CMP_EQ  = 2'd0;
    localparam logic [1:0] CMP_LT  = 2'd1;
    localparam logic [1:0] CMP_GT  = 2'd2;
    localparam logic [1:0] CMP_ILL = 2'd3;

    typedef enum logic [2:0] {
        BR_BEQ = 3'd0,
        BR_BNE = 3'd1,
        BR_BLT = 3'd2,
        BR_BGT = 3'd3,
        BR_BLE = 3'd4,
        BR_BGE = 3'd5,
        BR_JMP = 3'd6,
        BR_NOP = 3'd7
    } br_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-to-resolve request channel plus the resolve-to-fetch redirect channel.
interface branch_resolve_if #(
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      cmp_code;
    logic [2:0]      br_type;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] offset;
    logic            resolved_valid;
    logic            resolved_taken;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [PC_W-1:0] redirect_pc;
    logic            cmp_err;

    modport master (
        output in_valid, cmp_code, br_type, pc, offset, redirect_ready,
        input  in_ready, resolved_valid, resolved_taken, redirect_valid, redirect_pc, cmp_err
    );

    modport slave (
        input  in_valid, cmp_code, br_type, pc, offset, redirect_ready,
        output in_ready, resolved_valid, resolved_taken, redirect_valid, redirect_pc, cmp_err
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational taken/err decode from branch type and comparator code.
module branch_cond_eval
    import branch_resolve_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic [1:0] cmp_code,
    output logic       taken,
    output logic       err
);

    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        // Every conditional rule excludes CMP_ILL, so an illegal code is never taken.
        unique case (br_type_e'(br_type))
            BR_BEQ: taken = (cmp_code == CMP_EQ);
            BR_BNE: taken = (cmp_code == CMP_LT) || (cmp_code == CMP_GT);
            BR_BLT: taken = (cmp_code == CMP_LT);
            BR_BGT: taken = (cmp_code == CMP_GT);
            BR_BLE: taken = (cmp_code == CMP_EQ) || (cmp_code == CMP_LT);
            BR_BGE: taken = (cmp_code == CMP_EQ) || (cmp_code == CMP_GT);
            BR_JMP: taken = 1'b1;
            BR_NOP: taken = 1'b0;
        endcase
        if ((br_type != BR_JMP) && (br_type != BR_NOP) && (cmp_code == CMP_ILL)) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: registered taken decision, held redirect to fetch, wrong-path squash.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken/squashed event counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned SQUASH_SLOTS = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    branch_resolve_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]   stat_taken,
    output logic [31:0]   stat_not_taken,
    output logic [31:0]   stat_squashed
`endif
);

    localparam logic [2:0] SQ_INIT = 3'(SQUASH_SLOTS);

    state_e          state_q, state_d;
    logic [2:0]      squash_q, squash_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            res_valid_q, res_valid_d;
    logic            res_taken_q, res_taken_d;
    logic            cmp_err_q, cmp_err_d;

    logic            in_ready;
    logic            accept;
    logic            squash_hit;
    logic            taken;
    logic            err;
    logic [PC_W-1:0] target;

    branch_cond_eval u_cond_eval (
        .br_type  (bus.br_type),
        .cmp_code (bus.cmp_code),
        .taken    (taken),
        .err      (err)
    );

    assign in_ready   = (state_q == IDLE);
    assign accept     = bus.in_valid & in_ready;
    assign squash_hit = (squash_q != 3'd0);
    assign target     = bus.pc + PC_W'(1) + bus.offset;

    assign bus.in_ready       = in_ready;
    assign bus.redirect_valid = (state_q == HOLD);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.resolved_valid = res_valid_q;
    assign bus.resolved_taken = res_taken_q;
    assign bus.cmp_err        = cmp_err_q;

    always_comb begin
        state_d       = state_q;
        squash_d      = squash_q;
        redirect_pc_d = redirect_pc_q;
        res_valid_d   = 1'b0;
        res_taken_d   = 1'b0;
        cmp_err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (squash_hit) begin
                        squash_d = squash_q - 3'd1;
                    end else begin
                        res_valid_d = 1'b1;
                        res_taken_d = taken;
                        cmp_err_d   = err;
                        if (taken) begin
                            state_d       = HOLD;
                            squash_d      = SQ_INIT;
                            redirect_pc_d = target;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            squash_q      <= 3'd0;
            redirect_pc_q <= '0;
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            cmp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            squash_q      <= squash_d;
            redirect_pc_q <= redirect_pc_d;
            res_valid_q   <= res_valid_d;
            res_taken_q   <= res_taken_d;
            cmp_err_q     <= cmp_err_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic ev_taken, ev_not_taken, ev_squashed;

    assign ev_taken     = accept & ~squash_hit & taken;
    assign ev_not_taken = accept & ~squash_hit & ~taken;
    assign ev_squashed  = accept & squash_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
            stat_squashed  <= '0;
        end else begin
            if (ev_taken && !(&stat_taken))         stat_taken     <= stat_taken + 32'd1;
            if (ev_not_taken && !(&stat_not_taken)) stat_not_taken <= stat_not_taken + 32'd1;
            if (ev_squashed && !(&stat_squashed))   stat_squashed  <= stat_squashed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (SQUASH_SLOTS = 2, PC_W = 32).
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam int unsigned SQ = 2;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    branch_resolve_if #(.PC_W(32)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken, stat_not_taken, stat_squashed;
`endif

    branch_resolve #(
        .PC_W         (32),
        .SQUASH_SLOTS (SQ)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
        .stat_squashed  (stat_squashed)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One accepted request; returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [1:0] c,
                        input logic [31:0] p, input logic [31:0] o);
        bus.in_valid = 1'b1;
        bus.br_type  = t;
        bus.cmp_code = c;
        bus.pc       = p;
        bus.offset   = o;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Consume the wrong-path slots left by a taken redirect.
    task automatic drain();
        repeat (SQ) send(BR_NOP, CMP_EQ, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.resolved_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resolved_valid got %b want 0", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b0) begin n_fail++; $display("FAIL rst_resolved_taken got %b want 0", bus.resolved_taken); end
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redirect_valid got %b want 0", bus.redirect_valid); end
        n_checks++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redirect_pc got %h want 0", bus.redirect_pc); end
        n_checks++; if (bus.cmp_err !== 1'b0) begin n_fail++; $display("FAIL rst_cmp_err got %b want 0", bus.cmp_err); end
    endtask

    task automatic test_beq();
        bus.redirect_ready = 1'b1;
        send(BR_BEQ, CMP_EQ, 32'h100, 32'h10);
        n_checks++; if (bus.resolved_valid !== 1'b1) begin n_fail++; $display("FAIL beq_valid got %b want 1", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken got %b want 1", bus.resolved_taken); end
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_redir_valid got %b want 1", bus.redirect_valid); end
        n_checks++; if (bus.redirect_pc !== 32'h111) begin n_fail++; $display("FAIL beq_redir_pc got %h want 00000111", bus.redirect_pc); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL beq_hold_ready got %b want 0", bus.in_ready); end
        step();
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_redir_drop got %b want 0", bus.redirect_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_idle_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.resolved_valid !== 1'b0) begin n_fail++; $display("FAIL beq_pulse got %b want 0", bus.resolved_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.redirect_ready = 1'b1;
        send(BR_BLE, CMP_GT, 32'h200, 32'h4);
        n_checks++; if (bus.resolved_valid !== 1'b1) begin n_fail++; $display("FAIL ble_valid got %b want 1", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b0) begin n_fail++; $display("FAIL ble_taken got %b want 0", bus.resolved_taken); end
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ble_redir got %b want 0", bus.redirect_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ble_ready got %b want 1", bus.in_ready); end
        send(BR_BGE, CMP_GT, 32'h300, 32'hFFFF_FFFC);
        n_checks++; if (bus.resolved_valid !== 1'b1) begin n_fail++; $display("FAIL bge_valid got %b want 1", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b1) begin n_fail++; $display("FAIL bge_taken got %b want 1", bus.resolved_taken); end
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL bge_redir got %b want 1", bus.redirect_valid); end
        n_checks++; if (bus.redirect_pc !== 32'h2FD) begin n_fail++; $display("FAIL bge_redir_pc got %h want 000002fd", bus.redirect_pc); end
        step();
        drain();
    endtask

    task automatic test_jmp_hold();
        bus.redirect_ready = 1'b0;
        send(BR_JMP, CMP_LT, 32'h40, 32'h20);
        // A competing request must be refused while the redirect is held.
        bus.in_valid = 1'b1;
        bus.br_type  = BR_BEQ;
        bus.cmp_code = CMP_EQ;
        bus.pc       = 32'h999;
        bus.offset   = 32'h1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL jmp_hold_ready[%0d] got %b want 0", i, bus.in_ready); end
            n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jmp_hold_valid[%0d] got %b want 1", i, bus.redirect_valid); end
            n_checks++; if (bus.redirect_pc !== 32'h61) begin n_fail++; $display("FAIL jmp_hold_pc[%0d] got %h want 00000061", i, bus.redirect_pc); end
            if (i > 0) begin
                n_checks++; if (bus.resolved_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_hold_noaccept[%0d] got %b want 0", i, bus.resolved_valid); end
            end
            if (i < 4) step();
        end
        bus.in_valid       = 1'b0;
        bus.redirect_ready = 1'b1;
        step();
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_release_valid got %b want 0", bus.redirect_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL jmp_release_ready got %b want 1", bus.in_ready); end
        drain();
    endtask

    task automatic test_squash();
        bus.redirect_ready = 1'b1;
        send(BR_BEQ, CMP_EQ, 32'h10, 32'h0);
        n_checks++; if (bus.redirect_pc !== 32'h11) begin n_fail++; $display("FAIL sq_first_pc got %h want 00000011", bus.redirect_pc); end
        step();
        send(BR_BNE, CMP_LT, 32'h20, 32'h5);
        n_checks++; if (bus.resolved_valid !== 1'b0) begin n_fail++; $display("FAIL sq1_valid got %b want 0", bus.resolved_valid); end
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL sq1_redir got %b want 0", bus.redirect_valid); end
        // Idle cycles between wrong-path requests must not use up slots.
        step();
        step();
        send(BR_BNE, CMP_ILL, 32'h24, 32'h5);
        n_checks++; if (bus.resolved_valid !== 1'b0) begin n_fail++; $display("FAIL sq2_valid got %b want 0", bus.resolved_valid); end
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL sq2_redir got %b want 0", bus.redirect_valid); end
        n_checks++; if (bus.cmp_err !== 1'b0) begin n_fail++; $display("FAIL sq2_cmp_err got %b want 0", bus.cmp_err); end
        send(BR_BNE, CMP_GT, 32'h30, 32'h7);
        n_checks++; if (bus.resolved_valid !== 1'b1) begin n_fail++; $display("FAIL sq3_valid got %b want 1", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b1) begin n_fail++; $display("FAIL sq3_taken got %b want 1", bus.resolved_taken); end
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL sq3_redir got %b want 1", bus.redirect_valid); end
        n_checks++; if (bus.redirect_pc !== 32'h38) begin n_fail++; $display("FAIL sq3_pc got %h want 00000038", bus.redirect_pc); end
        step();
        drain();
    endtask

    task automatic test_illegal();
        bus.redirect_ready = 1'b1;
        send(BR_BLT, CMP_ILL, 32'h50, 32'h2);
        n_checks++; if (bus.cmp_err !== 1'b1) begin n_fail++; $display("FAIL blt3_err got %b want 1", bus.cmp_err); end
        n_checks++; if (bus.resolved_valid !== 1'b1) begin n_fail++; $display("FAIL blt3_valid got %b want 1", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b0) begin n_fail++; $display("FAIL blt3_taken got %b want 0", bus.resolved_taken); end
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL blt3_redir got %b want 0", bus.redirect_valid); end
        step();
        n_checks++; if (bus.cmp_err !== 1'b0) begin n_fail++; $display("FAIL blt3_err_pulse got %b want 0", bus.cmp_err); end
        send(BR_JMP, CMP_ILL, 32'h60, 32'h1);
        n_checks++; if (bus.resolved_taken !== 1'b1) begin n_fail++; $display("FAIL jmp3_taken got %b want 1", bus.resolved_taken); end
        n_checks++; if (bus.cmp_err !== 1'b0) begin n_fail++; $display("FAIL jmp3_err got %b want 0", bus.cmp_err); end
        n_checks++; if (bus.redirect_pc !== 32'h62) begin n_fail++; $display("FAIL jmp3_pc got %h want 00000062", bus.redirect_pc); end
        step();
        drain();
    endtask

    task automatic test_wrap_and_reset();
        bus.redirect_ready = 1'b0;
        send(BR_JMP, CMP_EQ, 32'hFFFF_FFFF, 32'h0);
        n_checks++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 00000000", bus.redirect_pc); end
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_hold got %b want 1", bus.redirect_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b want 0", bus.redirect_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.resolved_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_resolved got %b want 0", bus.resolved_valid); end
        reset_n = 1'b1;
        step();
        // Squash count was lost, so the next request resolves normally.
        send(BR_NOP, CMP_EQ, 32'h0, 32'h0);
        n_checks++; if (bus.resolved_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid got %b want 1", bus.resolved_valid); end
        n_checks++; if (bus.resolved_taken !== 1'b0) begin n_fail++; $display("FAIL post_rst_taken got %b want 0", bus.resolved_taken); end
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        reset_n            = 1'b0;
        bus.in_valid       = 1'b0;
        bus.br_type        = BR_NOP;
        bus.cmp_code       = CMP_EQ;
        bus.pc             = 32'h0;
        bus.offset         = 32'h0;
        bus.redirect_ready = 1'b0;
        #12;
        test_reset();
        reset_n = 1'b1;
        step();
        test_beq();
        test_back_to_back();
        test_jmp_hold();
        test_squash();
        test_illegal();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
